// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window feeder.
//   PIX_W  : width of one signed 4.16 pixel
//   WIN_W  : width of a full 3x3 window (9 pixels)
//   state_t: feeder FSM states
//   slot() : window slot index for row r (0 = y-1) and column c (0 = x-1)
package window_pkg;

    localparam int PIX_W = 20;
    localparam int WIN_W = 180;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_STEP = 3'd2,
        ST_WAIT = 3'd3,
        ST_EMIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic logic [3:0] slot(input logic [1:0] r, input logic [1:0] c);
        return ({2'b00, r} * 4'd3) + {2'b00, c};
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// 3x3 pixel window register.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : zero the whole window (row start)
//   shift      : move every column one step left; column c=2 becomes zero
//   load       : write load_data into slot load_k
//   window     : packed window, slot k at bits [k*PIX_W +: PIX_W]
// clear has priority over shift, shift over load; the feeder never
// asserts them together.
module window_shift_reg
    import window_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             load,
    input  logic [3:0]       load_k,
    input  logic [PIX_W-1:0] load_data,
    output logic [WIN_W-1:0] window
);

    logic [WIN_W-1:0] win_r;

    // Window storage: clear, column shift, or single-slot load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_r <= '0;
        end else if (clear) begin
            win_r <= '0;
        end else if (shift) begin
            for (int r = 0; r < 3; r++) begin
                win_r[(3*r)*PIX_W +: PIX_W]   <= win_r[(3*r+1)*PIX_W +: PIX_W];
                win_r[(3*r+1)*PIX_W +: PIX_W] <= win_r[(3*r+2)*PIX_W +: PIX_W];
                win_r[(3*r+2)*PIX_W +: PIX_W] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < 9; k++) begin
                if (load_k == 4'(k)) begin
                    win_r[k*PIX_W +: PIX_W] <= load_data;
                end
            end
        end
    end

    assign window = win_r;

endmodule

// File: rtl/window_feeder.sv
// Streams zero-padded 3x3 windows in raster order from the image memory
// to the convolution kernel stage, reusing columns by shifting.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_start           : frame start pulse (ignored while busy)
//   i_sel             : kernel select latched at start (single-kernel build)
//   o_busy, o_done    : frame in progress / end-of-frame pulse
//   o_ird, o_iaddr    : registered memory read strobe and address y*IMG_W+x
//   i_idata           : pixel returned one cycle after o_ird
//   o_valid, o_data   : window pulse and 180-bit window
//   o_sel             : kernel select accompanying o_valid
// Build option: WINDOW_FEEDER_DUAL_KERNEL_EN emits each window twice
// (o_sel 0 then 1) and removes i_sel.
module window_feeder
    import window_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
`ifndef WINDOW_FEEDER_DUAL_KERNEL_EN
    input  logic             i_sel,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ird,
    output logic [AW-1:0]    o_iaddr,
    input  logic [PIX_W-1:0] i_idata,
    output logic             o_valid,
    output logic [WIN_W-1:0] o_data,
    output logic             o_sel
);

    localparam logic [AW-1:0] W_AW   = AW'(IMG_W);
    localparam logic [AW-1:0] W_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] H_LAST = AW'(IMG_H - 1);

    typedef struct packed {
        logic          active;   // cycle is a read slot (real or padded)
        logic          rd;       // slot is inside the image
        logic [3:0]    k;        // destination window slot
        logic [AW-1:0] addr;
    } req_t;

    // Read slot decode. FILL slots 0..5 walk columns x, x+1 (window c=1,2)
    // top to bottom; STEP slots 0..2 walk column x+1 into c=2.
    function automatic req_t slot_req(input state_t st, input logic [2:0] s,
                                      input logic [AW-1:0] xx, input logic [AW-1:0] yy);
        req_t          q;
        logic [1:0]    r;
        logic [1:0]    c;
        logic [AW-1:0] col;
        logic [AW-1:0] row;
        logic          pad;
        q   = '0;
        r   = 2'd0;
        c   = 2'd0;
        col = xx;
        case (st)
            ST_FILL: begin
                q.active = 1'b1;
                if (s < 3'd3) begin
                    r   = s[1:0];
                    c   = 2'd1;
                    col = xx;
                end else begin
                    r   = 2'(s - 3'd3);
                    c   = 2'd2;
                    col = xx + AW'(1'b1);
                end
            end
            ST_STEP: begin
                q.active = 1'b1;
                r        = s[1:0];
                c        = 2'd2;
                col      = xx + AW'(1'b1);
            end
            default: q.active = 1'b0;
        endcase
        pad    = ((r == 2'd0) && (yy == '0)) || ((r == 2'd2) && (yy == H_LAST)) || (col == W_AW);
        row    = yy + AW'(r) - AW'(1'b1);
        q.rd   = q.active && !pad;
        q.k    = slot(r, c);
        q.addr = q.rd ? (row * W_AW + col) : '0;
        return q;
    endfunction

    state_t        state_r, state_nxt;
    logic [2:0]    slot_r, slot_nxt;
    logic [AW-1:0] x_r, x_nxt;
    logic [AW-1:0] y_r, y_nxt;
    logic          phase_r, phase_nxt;
    logic          last_emit_s;
    logic          emit_sel_s;
    req_t          req_r, req_nxt_s;
    logic          pend_active_r;
    logic          pend_rd_r;
    logic [3:0]    pend_k_r;
    logic          o_busy_r, o_done_r, o_valid_r, o_sel_r;
    logic [PIX_W-1:0] load_data_s;

`ifdef WINDOW_FEEDER_DUAL_KERNEL_EN
    assign last_emit_s = phase_r;
    assign emit_sel_s  = phase_nxt;
`else
    logic sel_r, sel_nxt;
    assign last_emit_s = 1'b1;
    assign emit_sel_s  = sel_nxt;

    // Kernel select held for the whole frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r <= 1'b0;
        end else begin
            sel_r <= sel_nxt;
        end
    end
`endif

    // Next-state, slot counter and raster position
    always_comb begin
        state_nxt = state_r;
        slot_nxt  = slot_r;
        x_nxt     = x_r;
        y_nxt     = y_r;
        phase_nxt = phase_r;
`ifndef WINDOW_FEEDER_DUAL_KERNEL_EN
        sel_nxt   = sel_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_FILL;
                    slot_nxt  = 3'd0;
                    x_nxt     = '0;
                    y_nxt     = '0;
`ifndef WINDOW_FEEDER_DUAL_KERNEL_EN
                    sel_nxt   = i_sel;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (slot_r == 3'd5) begin
                    state_nxt = ST_WAIT;
                    slot_nxt  = 3'd0;
                end else begin
                    slot_nxt  = slot_r + 3'd1;
                end
            end
            ST_STEP: begin
                if (slot_r == 3'd2) begin
                    state_nxt = ST_WAIT;
                    slot_nxt  = 3'd0;
                end else begin
                    slot_nxt  = slot_r + 3'd1;
                end
            end
            ST_WAIT: begin
                state_nxt = ST_EMIT;
                phase_nxt = 1'b0;
            end
            ST_EMIT: begin
                if (!last_emit_s) begin
                    phase_nxt = 1'b1;
                end else if (x_r < W_LAST) begin
                    x_nxt     = x_r + AW'(1'b1);
                    slot_nxt  = 3'd0;
                    state_nxt = ST_STEP;
                end else if (y_r < H_LAST) begin
                    x_nxt     = '0;
                    y_nxt     = y_r + AW'(1'b1);
                    slot_nxt  = 3'd0;
                    state_nxt = ST_FILL;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read request for the coming cycle, so o_ird/o_iaddr can be registered
    always_comb begin
        req_nxt_s = slot_req(state_nxt, slot_nxt, x_nxt, y_nxt);
    end

    // FSM state, counters and read pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            slot_r        <= 3'd0;
            x_r           <= '0;
            y_r           <= '0;
            phase_r       <= 1'b0;
            req_r         <= '0;
            pend_active_r <= 1'b0;
            pend_rd_r     <= 1'b0;
            pend_k_r      <= 4'd0;
        end else begin
            state_r       <= state_nxt;
            slot_r        <= slot_nxt;
            x_r           <= x_nxt;
            y_r           <= y_nxt;
            phase_r       <= phase_nxt;
            req_r         <= req_nxt_s;
            pend_active_r <= req_r.active;
            pend_rd_r     <= req_r.rd;
            pend_k_r      <= req_r.k;
        end
    end

    // Status and window handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_busy_r  <= 1'b0;
            o_done_r  <= 1'b0;
            o_valid_r <= 1'b0;
            o_sel_r   <= 1'b0;
        end else begin
            o_busy_r  <= (state_nxt != ST_IDLE);
            o_done_r  <= (state_nxt == ST_DONE);
            o_valid_r <= (state_nxt == ST_EMIT);
            o_sel_r   <= (state_nxt == ST_EMIT) ? emit_sel_s : 1'b0;
        end
    end

    // Padded slots load zero regardless of what the memory bus carries
    assign load_data_s = pend_rd_r ? i_idata : '0;

    window_shift_reg u_win (
        .clk       (clk),
        .reset     (reset),
        .clear     ((state_r == ST_FILL) && (slot_r == 3'd0)),
        .shift     ((state_r == ST_STEP) && (slot_r == 3'd0)),
        .load      (pend_active_r),
        .load_k    (pend_k_r),
        .load_data (load_data_s),
        .window    (o_data)
    );

    assign o_busy  = o_busy_r;
    assign o_done  = o_done_r;
    assign o_valid = o_valid_r;
    assign o_sel   = o_sel_r;
    assign o_ird   = req_r.rd;
    assign o_iaddr = req_r.addr;

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder on a 4x3 image.
module tb_window_feeder;
    import window_pkg::*;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 12;
    localparam int NPIX = W * H;
`ifdef WINDOW_FEEDER_DUAL_KERNEL_EN
    localparam int NEMIT = 2;
`else
    localparam int NEMIT = 1;
`endif
    localparam int DONE_OFF  = H * (8 + (NEMIT - 1) + (5 + (NEMIT - 1)) * (W - 1));
    localparam int EXP_READS = W * (3 * H - 2);

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_sel;
    logic             o_busy, o_done, o_ird, o_valid, o_sel;
    logic [AW-1:0]    o_iaddr;
    logic [PIX_W-1:0] i_idata;
    logic [WIN_W-1:0] o_data;

    always #5 clk = ~clk;

    window_feeder #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
`ifndef WINDOW_FEEDER_DUAL_KERNEL_EN
        .i_sel   (i_sel),
`endif
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_ird   (o_ird),
        .o_iaddr (o_iaddr),
        .i_idata (i_idata),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel)
    );

    typedef struct packed {
        logic [WIN_W-1:0] data;
        logic             sel;
    } exp_t;

    exp_t             exp_q[$];
    logic [PIX_W-1:0] mem [0:NPIX-1];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt, read_cnt, bad_reads, done_seen;
    int fill_cyc;

    task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Memory: one-cycle read latency; junk on the bus when no read was issued
    always @(posedge clk) begin
        if (o_ird && (o_iaddr < AW'(NPIX))) i_idata <= mem[o_iaddr];
        else i_idata <= 20'hABCDE;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Independent window model with zero padding
    function automatic logic [WIN_W-1:0] model_win(input int x, input int y);
        logic [WIN_W-1:0] w;
        int px, py;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px = x + c - 1;
                py = y + r - 1;
                if (px >= 0 && px < W && py >= 0 && py < H)
                    w[(3*r+c)*PIX_W +: PIX_W] = mem[py*W + px];
            end
        end
        return w;
    endfunction

    task automatic push_frame(input logic sel);
        exp_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                for (int k = 0; k < NEMIT; k++) begin
                    e.data = model_win(x, y);
                    e.sel  = (NEMIT == 2) ? (k == 1) : sel;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Output monitor: scoreboard pop on every window, read/done bookkeeping
    always @(negedge clk) begin
        exp_t e;
        if (o_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("win_data", o_data, e.data);
                check("win_sel", o_sel, e.sel);
            end
        end
        if (o_ird) begin
            read_cnt++;
            if (o_iaddr >= AW'(NPIX)) bad_reads++;
        end
        if (o_done) done_seen++;
    end

    task automatic start_frame(input logic sel);
        valid_cnt = 0;
        read_cnt  = 0;
        bad_reads = 0;
        done_seen = 0;
        push_frame(sel);
        @(negedge clk);
        i_start = 1'b1;
        i_sel   = sel;
        @(negedge clk);
        i_start  = 1'b0;
        fill_cyc = cyc;
        check("busy_at_fill", o_busy, 1'b1);
    endtask

    task automatic run_frame(input logic sel, input bit inject);
        int i;
        start_frame(sel);
        i = 0;
        while (!o_done && i < 400) begin
            @(negedge clk);
            i++;
            if (inject) begin
                i_start = (i == 10);
                i_sel   = ~sel;
            end
        end
        i_start = 1'b0;
        check("done_reached", o_done, 1'b1);
        check("done_cycle", cyc - fill_cyc, DONE_OFF);
        @(negedge clk);
        check("done_one_cycle", o_done, 1'b0);
        check("busy_after_done", o_busy, 1'b0);
        check("valid_count", valid_cnt, NPIX * NEMIT);
        check("read_count", read_cnt, EXP_READS);
        check("bad_reads", bad_reads, 0);
        check("done_count", done_seen, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int i;
        reset   = 1'b1;
        i_start = 1'b0;
        i_sel   = 1'b0;
        for (int a = 0; a < NPIX; a++) mem[a] = 20'(a + 1);
        repeat (3) @(negedge clk);
        check("rst_ctrl", {o_busy, o_done, o_ird, o_valid, o_sel}, 5'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctrl", {o_busy, o_done, o_ird, o_valid, o_sel}, 5'd0);
        check("idle_addr", o_iaddr, 0);
        check("idle_data", o_data, 0);

        // Frame 1: pixel = addr+1, sel 1, with a start pulse while busy
        run_frame(1'b1, 1'b1);

        // Frame 2: all-negative pixels, sel 0
        for (int a = 0; a < NPIX; a++) mem[a] = 20'hFFFFF - 20'(a);
        run_frame(1'b0, 1'b0);

        // Frame 3: reset during window 5, then restart
        for (int a = 0; a < NPIX; a++) mem[a] = 20'(a + 1);
        start_frame(1'b1);
        i = 0;
        while (valid_cnt < 4 * NEMIT && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("reach_window5", valid_cnt, 4 * NEMIT);
        repeat (2) @(negedge clk);
        check("busy_before_abort", o_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {o_busy, o_done, o_ird, o_valid, o_sel}, 5'd0);
        check("abort_addr", o_iaddr, 0);
        check("abort_data", o_data, 0);
        reset = 1'b0;
        exp_q.delete();
        done_seen = 0;
        repeat (100) @(negedge clk);
        check("no_done_after_abort", done_seen, 0);
        check("idle_after_abort", o_busy, 1'b0);
        run_frame(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_feeder.md
# window_feeder

Streams 3x3 pixel windows from the image memory into the convolution kernel stage, one window per output pixel in raster order, with zero padding outside the image. It is the producing end of the kernel's `i_valid`/`i_data`/`i_sel` interface. It reuses columns by shifting the window, so each steady-state window costs three memory reads instead of nine.

## Interface
- `IMG_W`, 64: image width in pixels (≥2).
- `IMG_H`, 64: image height in pixels (≥2).
- `AW`, 12: memory address width; must satisfy 2^AW ≥ IMG_W*IMG_H.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_start` in 1: one-cycle pulse that starts a frame; ignored while `o_busy`=1.
- `i_sel` in 1: kernel select, sampled at `i_start`, held for the frame (absent when `DUAL_KERNEL_EN` is defined).
- `o_busy` out 1: high from the cycle after an accepted `i_start` until `o_done`.
- `o_done` out 1: one-cycle pulse after the last window of the frame is emitted.
- `o_ird` out 1: memory read strobe.
- `o_iaddr` out AW: read address, y*IMG_W + x.
- `i_idata` in 20: signed 4.16 pixel, valid exactly one cycle after `o_ird`.
- `o_valid` out 1: window valid, one-cycle pulse per window (per kernel when dual).
- `o_data` out 180: window; slot k = 3*r + c at bits [k*20 +: 20]; r=0 is row y-1, c=0 is column x-1.
- `o_sel` out 1: kernel select accompanying `o_valid`.

## Operation
- FSM states: IDLE, FILL, STEP, WAIT, EMIT, DONE.
- IDLE: accept `i_start`; clear x and y to 0; go to FILL.
- FILL runs at row start. It uses 6 read slots, loading columns 0 and 1 (rows y-1, y, y+1; slot order column-major, top to bottom). The window's c=0 column is all zero. Then go to WAIT.
- STEP runs for x ≥ 1. It shifts the window left by one column, then uses 3 read slots for column x+1. If x+1 = IMG_W, the slots are zero and no read is issued. Then go to WAIT.
- Padding:
  - Any slot with row < 0, row ≥ IMG_H or column ≥ IMG_W still takes one cycle.
  - For such a slot `o_ird` stays 0 and a zero is loaded.
- WAIT: one cycle to capture the last returned datum.
- EMIT: `o_valid`=1 for one cycle with the complete window.
- After EMIT, advance:
  - If x < IMG_W-1: increment x, go to STEP.
  - Else if y < IMG_H-1: set x=0, increment y, go to FILL.
  - Else: go to DONE.
- DONE: `o_done`=1 for one cycle, then IDLE.
- No backpressure: the kernel accepts every valid window.
- Pixel values pass through unmodified; no arithmetic beyond address generation. The address is computed as y*IMG_W + x with AW-bit wrap-free arithmetic.

## Timing
- Reset values: all outputs 0, window register 0, FSM IDLE, x=y=0.
- Reset asserted mid-frame aborts immediately. No `o_done` is produced. The next `i_start` restarts from (0,0).
- `o_ird`/`o_iaddr` are registered. The read issued in cycle n returns in n+1 and is written to its slot in n+1.
- Row-start window: 8 cycles (6 FILL + WAIT + EMIT). Steady-state window: 5 cycles (3 STEP + WAIT + EMIT).
- Single-kernel frame: IMG_H*(8 + 5*(IMG_W-1)) cycles from the first FILL cycle to the last EMIT; DONE follows.
- `i_start` coincident with DONE is ignored. `i_start` in IDLE enters FILL on the next cycle.

## Configuration
- `WINDOW_FEEDER_DUAL_KERNEL_EN` defined:
  - EMIT lasts 2 cycles with the same `o_data`: first `o_sel`=0, then `o_sel`=1.
  - The `i_sel` port is removed.
  - Per-window cost is +1 cycle.
- Not defined: EMIT lasts 1 cycle; `o_sel` = the `i_sel` value latched at start.

## Structure
- Package `window_pkg` holds:
  - `PIX_W`=20 and `WIN_W`=180;
  - the FSM state enum;
  - the slot-index function slot(r,c) = 3*r + c.
- Sub-module `window_shift_reg`: the 3x3 register with shift-left and load-slot ports. The FSM, counters and address generator live in `window_feeder`.

## Test plan
- IMG_W=4, IMG_H=3, memory pixel = address+1 (20-bit), single kernel, `i_sel`=1.
  - Exactly 12 `o_valid` pulses, all with `o_sel`=1.
  - First window at (0,0) = slots {0,0,0, 0,1,2, 0,5,6}.
  - `o_done` 69 cycles after the first FILL cycle.
- Same setup, window (3,2) = {7,8,0, 11,12,0, 0,0,0}. Reads are never issued for y=3 or x=4.
- Dual-kernel build: each window appears on two consecutive cycles, `o_sel` 0 then 1, with identical `o_data`. 24 pulses total.
- Negative pixels (0xFFFFF) pass through bit-exact in every slot position.
- `reset` asserted during window 5:
  - All outputs are 0 the following cycle and no `o_done`.
  - A new `i_start` reproduces window (0,0) exactly.
- `i_start` pulsed while busy is ignored: the window count and `o_done` timing are unchanged.
